// File: rtl/mtrp_pkg.sv
// Shared MTRP line-code definitions: sample width, mid-scale level, tx FSM states.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package mtrp_pkg;

    localparam int SAMPLE_W = 12;
    localparam logic [SAMPLE_W-1:0] MID = 12'h800;

    typedef enum logic [1:0] {
        IDLE,
        PRE,
        START,
        DATA
    } state_t;

    function automatic logic [SAMPLE_W-1:0] pulse_level(
        input logic [SAMPLE_W-1:0] mid,
        input logic [10:0]         amp,
        input logic                pos
    );
        return pos ? (mid + {1'b0, amp}) : (mid - {1'b0, amp});
    endfunction

endpackage

// File: rtl/mtrp_tx_if.sv
// Byte-source handshake into the MTRP transmitter.
// Latency: n/a (wiring only).
// Backpressure: byte transfers on stb & rdy; source holds stb/dat until then.
interface mtrp_tx_if;

    logic [7:0] dat;
    logic       stb;
    logic       rdy;

    modport master (output dat, stb, input rdy);
    modport slave  (input dat, stb, output rdy);

endinterface

// File: rtl/mtrp_bit_timer.sv
// Bit-period timer: counts 0..2*HALF-1 while run, flags first half, half end and bit end.
// Latency: strobes are combinational from the count; count clears the edge after run drops.
// Backpressure: none.
module mtrp_bit_timer #(
    parameter int HALF = 8
) (
    input  logic clk,
    input  logic res,
    input  logic run,
    output logic first_half,
    output logic half_end,
    output logic bit_end
);

    localparam logic [8:0] HALF_M1 = 9'(HALF - 1);
    localparam logic [8:0] BIT_M1  = 9'(2 * HALF - 1);

    logic [8:0] cnt;

    always_ff @(posedge clk) begin
        if (res || !run) begin
            cnt <= '0;
        end else if (cnt == BIT_M1) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 9'd1;
        end
    end

    assign first_half = (cnt <= HALF_M1);
    assign half_end   = run && (cnt == HALF_M1);
    assign bit_end    = run && (cnt == BIT_M1);

endmodule

// File: rtl/mtrp_tx.sv
// MTRP bipolar RZ transmitter: bytes -> 12-bit offset-binary samples; MTRP_TX_PREAMBLE_EN adds an 8-pulse preamble from idle.
// Latency: acceptance at edge k puts the first pulse sample on MTRP/TXP/TXN from edge k+1.
// Backpressure: rdy only in IDLE and on the last cycle of data bit 0; stb is ignored otherwise.
module mtrp_tx
    import mtrp_pkg::*;
#(
    parameter int                  HALF = 8,
    parameter logic [SAMPLE_W-1:0] MID  = mtrp_pkg::MID
) (
    input  logic                clk,
    input  logic                res,
    mtrp_tx_if.slave            src,
    input  logic [10:0]         AMP,
    output logic [SAMPLE_W-1:0] MTRP,
    output logic                TXP,
    output logic                TXN,
    output logic                busy
);

`ifdef MTRP_TX_PREAMBLE_EN
    localparam state_t FIRST = PRE;
`else
    localparam state_t FIRST = START;
`endif

    state_t      state;
    logic [7:0]  shreg;
    logic [2:0]  bit_idx;
    logic [10:0] amp_q;
    logic        pol;
    logic        run;
    logic        first_half;
    logic        half_end;
    logic        bit_end;
    logic        last_cycle;
    logic        accept;
    logic        cur_one;
    logic        pulse;

    mtrp_bit_timer #(.HALF(HALF)) u_timer (
        .clk        (clk),
        .res        (res),
        .run        (run),
        .first_half (first_half),
        .half_end   (half_end),
        .bit_end    (bit_end)
    );

    assign run        = (state != IDLE);
    assign last_cycle = (state == DATA) && (bit_idx == 3'd0) && bit_end;
    assign src.rdy    = !res && ((state == IDLE) || last_cycle);
    assign accept     = src.stb && src.rdy;

    always_comb begin
        cur_one = 1'b0;
        case (state)
            PRE, START: cur_one = 1'b1;
            DATA:       cur_one = shreg[7];
            default:    cur_one = 1'b0;
        endcase
    end

    assign pulse = run && first_half && cur_one;

    // pol = 1 means the next pulse is positive; it flips once each pulse half completes.
    always_ff @(posedge clk) begin
        if (res) begin
            state <= IDLE;
            pol   <= 1'b1;
            busy  <= 1'b0;
            MTRP  <= MID;
            TXP   <= 1'b0;
            TXN   <= 1'b0;
        end else begin
            MTRP <= pulse ? pulse_level(MID, amp_q, pol) : MID;
            TXP  <= pulse && pol;
            TXN  <= pulse && !pol;
            if (pulse && half_end) begin
                pol <= !pol;
            end

            case (state)
                IDLE: begin
                    if (accept) begin
                        state   <= FIRST;
                        bit_idx <= 3'd7;
                        shreg   <= src.dat;
                        amp_q   <= AMP;
                        busy    <= 1'b1;
                    end
                end
`ifdef MTRP_TX_PREAMBLE_EN
                PRE: begin
                    if (bit_end) begin
                        bit_idx <= bit_idx - 3'd1;
                        if (bit_idx == 3'd0) begin
                            state <= START;
                        end
                    end
                end
`endif
                START: begin
                    if (bit_end) begin
                        state   <= DATA;
                        bit_idx <= 3'd7;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        shreg   <= {shreg[6:0], 1'b0};
                        bit_idx <= bit_idx - 3'd1;
                        if (bit_idx == 3'd0) begin
                            // back-to-back byte goes straight to its start mark, never a preamble
                            if (accept) begin
                                state <= START;
                                shreg <= src.dat;
                                amp_q <= AMP;
                            end else begin
                                state <= IDLE;
                                busy  <= 1'b0;
                            end
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/mtrp_tx.md
# mtrp_tx

- Bipolar return-to-zero (MTRP) line-code transmitter.
- Serialises bytes into a 12-bit offset-binary sample stream that drives the same signal path the MTRP receiver consumes.
- Ones become alternating-polarity pulses of programmable amplitude; zeros and idle sit at mid-scale.
- Sits between a byte source (valid/ready) and the DAC sample bus, and is the transmit end of the MTRP link.

## Interface
Parameters:
- HALF, 8: cycles per half-bit; bit period = 2*HALF cycles; legal range 2..255.
- MID, 12'h800: mid-scale (zero-level) sample value.

Ports:
- clk  in  1  system clock; all logic rising-edge.
- res  in  1  reset; synchronous, active-high.
- dat  in  8  byte to send.
- stb  in  1  byte valid.
- rdy  out  1  block can accept a byte this cycle.
- AMP  in  11  pulse amplitude in LSB above/below MID.
- MTRP  out  12  registered output sample.
- TXP  out  1  high while a positive pulse is on MTRP.
- TXN  out  1  high while a negative pulse is on MTRP.
- busy  out  1  high from byte acceptance until the last bit period ends.

## Operation
- A byte is accepted on a clock edge where stb & rdy; dat and AMP are latched at that edge.
- Frame order: optional preamble, then start mark (a one), then 8 data bits MSB-first. There is no stop bit.
- Bit period:
  - first HALF cycles: pulse level for a one, MID for a zero;
  - last HALF cycles: MID.
- Pulse levels: positive = MID + AMP, negative = MID - AMP, computed in 12 bits. AMP ≤ 11'h7FF guarantees no wrap.
- Polarity register:
  - toggles after every pulse sent (preamble, start or data one);
  - persists across bytes and across idle;
  - reset value = positive.
- TXP/TXN follow the polarity of the current pulse half; both are 0 on MID halves. With AMP = 0, MTRP stays at MID but TXP/TXN still assert.
- States:
  - IDLE: rdy = 1, MTRP = MID. stb → PRE (macro on) or START.
  - PRE: 8 consecutive one-bits. → START.
  - START: one bit period. → DATA.
  - DATA: 8 bit periods, bit counter 7 → 0. → END.
  - END: internal decision point at the final cycle of bit 0.
    - If stb & rdy: accept, → START (no preamble on back-to-back).
    - Otherwise → IDLE.
- rdy = 1 in IDLE and on the final cycle of data bit 0; 0 elsewhere.
- stb while rdy = 0 is ignored; the source must hold it.
- res asserted mid-frame: abort at the next edge and drop the partial byte.
  - MTRP = MID, TXP = TXN = 0, busy = 0, polarity = positive, state = IDLE.

## Timing
- Reset values: MTRP = MID, TXP = 0, TXN = 0, busy = 0, rdy = 0 while res high, rdy = 1 the first cycle after res falls.
- Latency: acceptance at edge k → first pulse sample on MTRP from edge k+1, i.e. one registered stage.
- Frame length:
  - without preamble: 9 × 2·HALF cycles;
  - with preamble: 17 × 2·HALF cycles.
- Back-to-back bytes have no gap: the next start pulse follows the last data bit's MID half directly.
- busy rises with acceptance, is continuous across back-to-back bytes, and falls the cycle the FSM enters IDLE.
- TXP/TXN are registered in the same stage as MTRP, so they are cycle-aligned with it.

## Configuration
- MTRP_TX_PREAMBLE_EN defined: every frame starting from IDLE is preceded by 8 alternating-polarity one-bits. These let the receiver settle its Xmax/Xmin and REF_P/REF_N thresholds.
- Not defined: PRE state is absent and frames start directly with the start mark.
- Back-to-back frames never carry a preamble in either build.

## Structure
- Shared package mtrp_pkg: MID constant, state enumeration (IDLE, PRE, START, DATA), and a sample-width constant of 12 shared with the receiver side.
- One sub-module, mtrp_bit_timer:
  - counts 0..2·HALF-1;
  - outputs a half-boundary strobe and a bit-end strobe.
- The FSM, shift register, polarity register and output mux stay in mtrp_tx.

## Test plan
1. Reset, HALF = 4, no macro: during and after res, MTRP = 12'h800, TXP = TXN = 0, rdy = 1 after release.
2. dat = 8'hA5, AMP = 11'h400:
   - pulse sequence start, 1, 1, 1, 1 on bits S, 7, 5, 2, 0;
   - levels C00, 400, C00, 400, C00;
   - each pulse 4 cycles, then 4 cycles at 800;
   - frame = 72 cycles.
3. Second byte 8'h80 after IDLE: start pulse is negative (12'h400), data bit 7 positive, polarity continuity across idle confirmed.
4. stb held with 8'hFF then 8'h00:
   - rdy pulses one cycle at the end of bit 0;
   - no gap between frames;
   - busy stays 1 for 144 cycles.
5. res asserted mid-DATA of 8'hFF: next cycle MTRP = 800, busy = 0, and the following byte's start pulse is positive.
6. MTRP_TX_PREAMBLE_EN, dat = 8'h00, AMP = 11'h7FF:
   - 8 preamble pulses alternating FFF/001, then start pulse FFF;
   - data all 800;
   - frame = 136 cycles.
